code_checker: RTL and testbench

CODE_CHECKER -- requirements
Module: code_checker

---
 rtl/code_checker.sv | 157 +++++++++++++++
 tb/tb_code_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_checker.sv
// Keypad code lock: four-digit entry, timed unlock, password programming and
// a timed lockout after repeated wrong attempts.
//
// state     | meaning
// LOCKED    | collecting digits; '#' checks the entry against the password
// OPEN      | lock open, down-counter running toward automatic relock
// PROG      | lock open, new password being entered, counter frozen
// ALARM     | lockout after MAX_TRIES wrong attempts, keys ignored
module code_checker #(
  parameter logic [15:0] PASSWORD       = 16'h1234,
  parameter int          UNLOCK_CYCLES  = 1000,
  parameter int          LOCKOUT_CYCLES = 5000,
  parameter int          MAX_TRIES      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Code,
  input  logic       Valid,
  output logic       Unlock,
  output logic       Alarm,
  output logic       Error,
  output logic [2:0] Digits,
  output logic       Prog
);

  localparam int CNT_MAX = ((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES) - 1;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int TW      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [CW-1:0] UNLOCK_LOAD  = CW'(UNLOCK_CYCLES - 1);
  localparam logic [CW-1:0] LOCKOUT_LOAD = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TRIES_LAST   = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {ST_LOCKED, ST_OPEN, ST_PROG, ST_ALARM} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_valid_q;
  logic [15:0]    r_buf, w_buf_nxt;
  logic [2:0]     r_digits, w_digits_nxt;
  logic [TW-1:0]  r_tries, w_tries_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [15:0]    r_pwd, w_pwd_nxt;
  logic           r_error, w_error_nxt;
  logic           r_unlock, r_alarm, r_prog;

  logic w_event, w_digit, w_star, w_hash, w_shift;

  assign w_event = Valid & ~r_valid_q;
  assign w_digit = w_event & (Code <= 4'd9);
  assign w_star  = w_event & (Code == 4'd10);
  assign w_hash  = w_event & (Code == 4'd11);
  // The buffer saturates at four digits rather than wrapping.
  assign w_shift = w_digit & (r_digits != 3'd4);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_LOCKED;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_digits_nxt = r_digits;
    w_tries_nxt  = r_tries;
    w_cnt_nxt    = r_cnt;
    w_pwd_nxt    = r_pwd;
    w_error_nxt  = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (w_shift) begin
          w_buf_nxt    = {r_buf[11:0], Code};
          w_digits_nxt = r_digits + 3'd1;
        end else if (w_star) begin
          w_buf_nxt    = '0;
          w_digits_nxt = '0;
        end else if (w_hash) begin
          w_buf_nxt    = '0;
          w_digits_nxt = '0;
          if (r_digits == 3'd4 && r_buf == r_pwd) begin
            w_state_nxt = ST_OPEN;
            w_tries_nxt = '0;
            w_cnt_nxt   = UNLOCK_LOAD;
          end else begin
            w_error_nxt = 1'b1;
            if (r_tries == TRIES_LAST) begin
              w_state_nxt = ST_ALARM;
              w_tries_nxt = '0;
              w_cnt_nxt   = LOCKOUT_LOAD;
            end else begin
              w_tries_nxt = r_tries + 1'b1;
            end
          end
        end
      end
      ST_OPEN: begin
        if (w_hash)             w_state_nxt = ST_LOCKED;
        else if (w_star)        w_state_nxt = ST_PROG;
        else if (r_cnt == '0)   w_state_nxt = ST_LOCKED;
        else                    w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_PROG: begin
        if (w_shift) begin
          w_buf_nxt    = {r_buf[11:0], Code};
          w_digits_nxt = r_digits + 3'd1;
        end else if (w_hash || w_star) begin
          if (w_hash) begin
            if (r_digits == 3'd4) w_pwd_nxt   = r_buf;
            else                  w_error_nxt = 1'b1;
          end
          w_state_nxt  = ST_OPEN;
          w_cnt_nxt    = UNLOCK_LOAD;
          w_buf_nxt    = '0;
          w_digits_nxt = '0;
        end
      end
      ST_ALARM: begin
        if (r_cnt == '0) w_state_nxt = ST_LOCKED;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
  end

  // valid_q resets high so a key held through reset release is not taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid_q <= 1'b1;
      r_buf     <= '0;
      r_digits  <= '0;
      r_tries   <= '0;
      r_cnt     <= '0;
      r_pwd     <= PASSWORD;
      r_error   <= 1'b0;
      r_unlock  <= 1'b0;
      r_alarm   <= 1'b0;
      r_prog    <= 1'b0;
    end else begin
      r_valid_q <= Valid;
      r_buf     <= w_buf_nxt;
      r_digits  <= w_digits_nxt;
      r_tries   <= w_tries_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pwd     <= w_pwd_nxt;
      r_error   <= w_error_nxt;
      r_unlock  <= (w_state_nxt == ST_OPEN) || (w_state_nxt == ST_PROG);
      r_alarm   <= (w_state_nxt == ST_ALARM);
      r_prog    <= (w_state_nxt == ST_PROG);
    end
  end

  assign Unlock = r_unlock;
  assign Alarm  = r_alarm;
  assign Error  = r_error;
  assign Digits = r_digits;
  assign Prog   = r_prog;

endmodule

// File: tb/tb_code_checker.sv
// Bench for code_checker: directed scenarios then random key traffic, all
// checked every clock against an abstract model of the lock.
module tb_code_checker;

  localparam int U  = 60;
  localparam int L  = 80;
  localparam int MT = 3;

  localparam int S_LOCKED = 0;
  localparam int S_OPEN   = 1;
  localparam int S_PROG   = 2;
  localparam int S_ALARM  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Code  = 4'd0;
  logic       Valid = 1'b0;
  logic       Unlock, Alarm, Error, Prog;
  logic [2:0] Digits;

  always #5 clock = ~clock;

  code_checker #(
    .PASSWORD(16'h1234), .UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L), .MAX_TRIES(MT)
  ) dut (
    .clock(clock), .reset(reset), .Code(Code), .Valid(Valid),
    .Unlock(Unlock), .Alarm(Alarm), .Error(Error), .Digits(Digits), .Prog(Prog)
  );

  int m_state, m_tries, m_deadline, cyc;
  int m_entry[$];
  int m_pwd[4];
  bit m_err, m_vq;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit entry_is_pwd();
    if (m_entry.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_entry[i] != m_pwd[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = S_LOCKED; m_tries = 0; m_deadline = 0; m_err = 0; m_vq = 1;
    m_entry.delete();
    m_pwd[0] = 1; m_pwd[1] = 2; m_pwd[2] = 3; m_pwd[3] = 4;
  endtask

  task automatic model_key(input int c);
    case (m_state)
      S_LOCKED: begin
        if (c <= 9) begin
          if (m_entry.size() < 4) m_entry.push_back(c);
        end else if (c == 10) begin
          m_entry.delete();
        end else if (c == 11) begin
          if (entry_is_pwd()) begin
            m_state = S_OPEN; m_tries = 0; m_deadline = cyc + U;
          end else begin
            m_err = 1; m_tries++;
            if (m_tries == MT) begin
              m_state = S_ALARM; m_tries = 0; m_deadline = cyc + L;
            end
          end
          m_entry.delete();
        end
      end
      S_OPEN: begin
        if (c == 11) m_state = S_LOCKED;
        else if (c == 10) m_state = S_PROG;
      end
      S_PROG: begin
        if (c <= 9) begin
          if (m_entry.size() < 4) m_entry.push_back(c);
        end else if (c == 10 || c == 11) begin
          if (c == 11) begin
            if (m_entry.size() == 4) for (int i = 0; i < 4; i++) m_pwd[i] = m_entry[i];
            else m_err = 1;
          end
          m_state = S_OPEN; m_deadline = cyc + U;
          m_entry.delete();
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("unlock", 16'(Unlock), 16'(m_state == S_OPEN || m_state == S_PROG));
    chk("alarm",  16'(Alarm),  16'(m_state == S_ALARM));
    chk("prog",   16'(Prog),   16'(m_state == S_PROG));
    chk("error",  16'(Error),  16'(m_err));
    chk("digits", 16'(Digits), 16'(m_entry.size()));
  endtask

  task automatic step();
    bit ev;
    int c;
    @(posedge clock);
    cyc++;
    ev = Valid && !m_vq;
    c  = int'(Code);
    m_vq = Valid;
    m_err = 0;
    if ((m_state == S_OPEN || m_state == S_ALARM) && cyc >= m_deadline) m_state = S_LOCKED;
    if (ev) model_key(c);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int c, input int hold, input int gap);
    int guard = 0;
    if (m_state == S_OPEN || m_state == S_ALARM) begin
      if (cyc + 12 >= m_deadline)
        while (cyc < m_deadline && guard < 20000) begin step(); guard++; end
    end
    Code = 4'(c); Valid = 1'b1;
    repeat (hold) step();
    Valid = 1'b0; Code = 4'($urandom_range(0, 15));
    repeat (gap) step();
  endtask

  task automatic keys(input int n, input logic [63:0] seq);
    logic [63:0] s;
    for (int i = 0; i < n; i++) begin
      s = seq >> (4 * (n - 1 - i));
      press(int'(s[3:0]), $urandom_range(1, 3), $urandom_range(1, 2));
    end
  endtask

  task automatic do_reset(input bit hold_valid);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_unlock", 16'(Unlock), 16'd0);
    chk("rst_alarm",  16'(Alarm),  16'd0);
    chk("rst_error",  16'(Error),  16'd0);
    chk("rst_prog",   16'(Prog),   16'd0);
    chk("rst_digits", 16'(Digits), 16'd0);
    if (hold_valid) begin Code = 4'd1; Valid = 1'b1; end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int r, p[4];
    cyc = 0;
    do_reset(1'b0);
    idle(2);

    // Correct code opens; model checks the exact relock clock.
    keys(5, 64'h1234B);
    chk("open_after_hash", 16'(Unlock), 16'd1);
    idle(U + 5);

    // Three wrong attempts lock out; keys ignored during lockout.
    keys(5, 64'h1235B);
    keys(5, 64'h1235B);
    keys(5, 64'h1235B);
    chk("alarm_after_3", 16'(Alarm), 16'd1);
    keys(5, 64'h1234B);
    idle(L + 5);

    // Programming a new password.
    keys(5, 64'h1234B);
    keys(1, 64'hA);
    keys(5, 64'h9876B);
    keys(1, 64'hB);
    keys(5, 64'h9876B);
    chk("new_pwd_opens", 16'(Unlock), 16'd1);
    keys(1, 64'hB);
    keys(5, 64'h1234B);

    do_reset(1'b0);
    idle(2);

    // Long hold yields one digit; digit count saturates.
    press(5, 50, 2);
    chk("long_hold_digits", 16'(Digits), 16'd1);
    keys(7, 64'hA123456);
    chk("digits_saturate", 16'(Digits), 16'd4);
    keys(1, 64'hB);
    chk("sat_buf_opens", 16'(Unlock), 16'd1);
    keys(1, 64'hB);

    // '*' clears entry but not the try counter.
    keys(8, 64'h12A1234B);
    keys(1, 64'hB);
    keys(5, 64'h1235B);
    keys(5, 64'h1235B);
    keys(3, 64'h12A);
    keys(5, 64'h1235B);
    chk("star_keeps_tries", 16'(Alarm), 16'd1);
    idle(L + 5);

    // Invalid codes change nothing.
    keys(6, 64'h12CDEF);
    chk("invalid_ignored", 16'(Digits), 16'd2);
    keys(1, 64'hA);

    // Reset during programming restores the default password; a held key
    // at release is not taken.
    keys(5, 64'h1234B);
    keys(5, 64'hA9876);
    do_reset(1'b1);
    idle(3);
    chk("held_key_ignored", 16'(Digits), 16'd0);
    Valid = 1'b0;
    idle(2);
    keys(5, 64'h1234B);
    chk("pwd_restored", 16'(Unlock), 16'd1);
    keys(1, 64'hB);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin
          for (int k = 0; k < 4; k++) p[k] = m_pwd[k];
          for (int k = 0; k < 4; k++) press(p[k], $urandom_range(1, 4), $urandom_range(1, 3));
          press(11, $urandom_range(1, 4), $urandom_range(1, 3));
        end
        2: press(10, $urandom_range(1, 4), $urandom_range(1, 3));
        3: press(11, $urandom_range(1, 4), $urandom_range(1, 3));
        4: idle($urandom_range(1, 90));
        5: press($urandom_range(12, 15), $urandom_range(1, 4), $urandom_range(1, 3));
        default: press($urandom_range(0, 9), $urandom_range(1, 4), $urandom_range(1, 3));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
